acc_auth_engine: RTL and testbench
==================================

ACC_AUTH_ENGINE -- requirements
Module: acc_auth_engine

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NUM_ACCOUNTS, 10: database entries, 1..16.
- ACC_W, 4: account-number width.
- PIN_W, 16: PIN width.
- MAX_TRIES, 3: consecutive failed PIN attempts before lockout, 1..7.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: single clock; all state on rising edge.
- rst, in, 1: asynchronous, active-high reset.
- req_valid, in, 1: request offered.
- req_ready, out, 1: engine idle, request accepted when req_valid and req_ready are both high.
- req_op, in, 2: 0=VERIFY, 1=CHANGE_PIN, 2/3 reserved.
- acc_num, in, ACC_W: account number.
- pin, in, PIN_W: presented PIN.
- new_pin, in, PIN_W: replacement PIN (CHANGE_PIN only).
- rsp_valid, out, 1: response available.
- rsp_ready, in, 1: response consumed when rsp_valid and rsp_ready are both high.
- rsp_status, out, 3: 0=OK, 1=NOT_FOUND, 2=BAD_PIN, 3=LOCKED, 4=SAME_PIN, 5=BAD_OP.
- acc_index_out, out, 4: matched index; 0 unless status is OK, BAD_PIN, LOCKED or SAME_PIN.
- acc_found, out, 1: account matched (valid with rsp_valid).

Function
REQ-003 FSM states SHALL be IDLE, SEARCH, CHECK, RESP; req_ready SHALL be high only in IDLE.
REQ-004 On acceptance, acc_num, pin, new_pin and req_op SHALL be registered, and the FSM SHALL enter SEARCH with index 0 (reserved op: go directly to RESP with BAD_OP).
REQ-005 SEARCH SHALL compare one entry per cycle. On a match it SHALL latch the index and enter CHECK. After entry NUM_ACCOUNTS-1 without a match it SHALL enter RESP with NOT_FOUND.
REQ-006 Latency SHALL be fixed: rsp_valid rises k+2 cycles after acceptance for a match at index k; NOT_FOUND rises NUM_ACCOUNTS+1 cycles after acceptance.
REQ-007 CHECK SHALL apply these rules in priority order:
- locked -> LOCKED;
- pin mismatch -> BAD_PIN and increment fail counter, saturating at MAX_TRIES;
- CHANGE_PIN with new_pin equal to stored PIN -> SAME_PIN;
- CHANGE_PIN otherwise -> write new_pin to the entry, OK;
- VERIFY otherwise -> OK.
REQ-008 A correct PIN on an unlocked account SHALL clear its fail counter; an account SHALL be locked when its counter equals MAX_TRIES.
REQ-009 RESP SHALL hold rsp_valid and all response outputs stable until rsp_ready is high, then return to IDLE; if rsp_ready is already high, RESP SHALL last one cycle.
REQ-010 A PIN write SHALL be visible to the next accepted request.
REQ-011 acc_num 0 SHALL never match; req_valid outside IDLE SHALL be ignored with no side effects.
REQ-012 The database SHALL hold account number i+1 at index i. PIN reset values for indices 0..9 SHALL be 1234, 2345, 3456, 4567, 5678, 6789, 7890, 8901, 9012, 7123; index i>=10 SHALL reset to 1000+i.

Reset
REQ-013 While rst is high, the following SHALL hold:
- state IDLE, req_ready 1 (after rst falls);
- rsp_valid 0, rsp_status 0, acc_index_out 0, acc_found 0;
- all fail counters 0, all PINs at reset values.
REQ-014 Reset asserted mid-transaction SHALL abort it with no response and no PIN or counter update.

Configuration
REQ-015 Macro AUTH_LOCKOUT_EN defined: fail counters and LOCKED behaviour per REQ-007/008. Undefined: no counters implemented, LOCKED never returned, BAD_PIN has no side effect.

Verification
REQ-016 VERIFY acc 3, pin 3456 -> rsp_valid 4 cycles after accept, OK, acc_index_out 2, acc_found 1.
REQ-017 VERIFY acc 11 -> NOT_FOUND after 11 cycles, acc_found 0, acc_index_out 0.
REQ-018 With AUTH_LOCKOUT_EN, the lockout sequence SHALL behave as follows:
- VERIFY acc 1 with pin 1111 three times -> BAD_PIN x3;
- then pin 1234 -> LOCKED;
- after rst, pin 1234 -> OK.
REQ-019 PIN change sequence SHALL behave as follows:
- CHANGE_PIN acc 5, pin 5678, new 5678 -> SAME_PIN;
- then new 4321 -> OK;
- VERIFY 5678 -> BAD_PIN, VERIFY 4321 -> OK.
REQ-020 Handshake: hold rsp_ready low 5 cycles -> outputs stable and req_ready low throughout; req_valid pulsed mid-search -> ignored; req_op 3 -> BAD_OP.

Source files
------------

// File: rtl/acc_auth_engine_if.sv
// Request/response handshake bundle for acc_auth_engine.
// master drives requests and consumes responses; slave is the engine side.
interface acc_auth_engine_if #(
  parameter int unsigned ACC_W = 4,
  parameter int unsigned PIN_W = 16
) ();
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [ACC_W-1:0] acc_num;
  logic [PIN_W-1:0] pin;
  logic [PIN_W-1:0] new_pin;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [2:0]       rsp_status;
  logic [3:0]       acc_index_out;
  logic             acc_found;

  modport master (
    output req_valid, req_op, acc_num, pin, new_pin, rsp_ready,
    input  req_ready, rsp_valid, rsp_status, acc_index_out, acc_found
  );

  modport slave (
    input  req_valid, req_op, acc_num, pin, new_pin, rsp_ready,
    output req_ready, rsp_valid, rsp_status, acc_index_out, acc_found
  );
endinterface

// File: rtl/acc_auth_engine.sv
// Account PIN verify / change engine with a linear one-entry-per-cycle search.
// Define AUTH_LOCKOUT_EN to add per-account fail counters and LOCKED responses.
module acc_auth_engine #(
  parameter int unsigned NUM_ACCOUNTS = 10,
  parameter int unsigned ACC_W        = 4,
  parameter int unsigned PIN_W        = 16,
  parameter int unsigned MAX_TRIES    = 3
) (
  input logic              clk,
  input logic              rst,
  acc_auth_engine_if.slave bus
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSearch = 2'd1;
  localparam logic [1:0] StCheck  = 2'd2;
  localparam logic [1:0] StResp   = 2'd3;

  localparam logic [1:0] OpVerify = 2'd0;
  localparam logic [1:0] OpChange = 2'd1;

  localparam logic [2:0] StatOk       = 3'd0;
  localparam logic [2:0] StatNotFound = 3'd1;
  localparam logic [2:0] StatBadPin   = 3'd2;
  localparam logic [2:0] StatLocked   = 3'd3;
  localparam logic [2:0] StatSamePin  = 3'd4;
  localparam logic [2:0] StatBadOp    = 3'd5;

  localparam logic [3:0] LastIdx = 4'(NUM_ACCOUNTS - 1);

  function automatic logic [PIN_W-1:0] pin_reset(input int i);
    case (i)
      0:       return PIN_W'(1234);
      1:       return PIN_W'(2345);
      2:       return PIN_W'(3456);
      3:       return PIN_W'(4567);
      4:       return PIN_W'(5678);
      5:       return PIN_W'(6789);
      6:       return PIN_W'(7890);
      7:       return PIN_W'(8901);
      8:       return PIN_W'(9012);
      9:       return PIN_W'(7123);
      default: return PIN_W'(1000 + i);
    endcase
  endfunction

  logic [1:0]       state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic             found_q, found_d;
  logic [2:0]       status_q, status_d;
  logic [3:0]       index_q, index_d;
  logic             acc_found_q, acc_found_d;
  logic [1:0]       op_q;
  logic [ACC_W-1:0] acc_q;
  logic [PIN_W-1:0] pin_q;
  logic [PIN_W-1:0] new_pin_q;
  logic [PIN_W-1:0] pins_q [NUM_ACCOUNTS];
  logic [PIN_W-1:0] cur_pin;
  logic             entry_match;
  logic             accept;
  logic             pin_we;
  logic             locked;

  assign accept  = (state_q == StIdle) && bus.req_valid;
  assign cur_pin = pins_q[idx_q];
  // Entry i holds account i+1; account 0 is never valid, even if i+1 wraps to 0.
  assign entry_match = (acc_q != '0) && (acc_q == ACC_W'({1'b0, idx_q} + 5'd1));

`ifdef AUTH_LOCKOUT_EN
  logic [2:0] fail_q [NUM_ACCOUNTS];
  logic       fail_inc;
  logic       fail_clr;

  assign locked = (fail_q[idx_q] == 3'(MAX_TRIES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) fail_q[i] <= '0;
    end else if (fail_clr) begin
      fail_q[idx_q] <= '0;
    end else if (fail_inc && (fail_q[idx_q] != 3'(MAX_TRIES))) begin
      fail_q[idx_q] <= fail_q[idx_q] + 3'd1;
    end
  end
`else
  assign locked = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    found_d     = found_q;
    status_d    = status_q;
    index_d     = index_q;
    acc_found_d = acc_found_q;
    pin_we      = 1'b0;
`ifdef AUTH_LOCKOUT_EN
    fail_inc    = 1'b0;
    fail_clr    = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          if (bus.req_op != OpVerify && bus.req_op != OpChange) begin
            state_d     = StResp;
            status_d    = StatBadOp;
            index_d     = '0;
            acc_found_d = 1'b0;
          end else begin
            state_d = StSearch;
            idx_d   = '0;
            found_d = 1'b0;
          end
        end
      end
      StSearch: begin
        if (entry_match) begin
          found_d = 1'b1;
          state_d = StCheck;
        end else if (idx_q == LastIdx) begin
          // Misses also pass through CHECK so NOT_FOUND latency is NUM_ACCOUNTS+1.
          state_d = StCheck;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      StCheck: begin
        state_d     = StResp;
        acc_found_d = found_q;
        index_d     = found_q ? idx_q : 4'd0;
        if (!found_q) begin
          status_d = StatNotFound;
        end else if (locked) begin
          status_d = StatLocked;
        end else if (pin_q != cur_pin) begin
          status_d = StatBadPin;
`ifdef AUTH_LOCKOUT_EN
          fail_inc = 1'b1;
`endif
        end else begin
`ifdef AUTH_LOCKOUT_EN
          fail_clr = 1'b1;
`endif
          if (op_q == OpChange && new_pin_q == cur_pin) begin
            status_d = StatSamePin;
          end else begin
            pin_we   = (op_q == OpChange);
            status_d = StatOk;
          end
        end
      end
      StResp: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      found_q     <= 1'b0;
      status_q    <= '0;
      index_q     <= '0;
      acc_found_q <= 1'b0;
      op_q        <= '0;
      acc_q       <= '0;
      pin_q       <= '0;
      new_pin_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      found_q     <= found_d;
      status_q    <= status_d;
      index_q     <= index_d;
      acc_found_q <= acc_found_d;
      if (accept) begin
        op_q      <= bus.req_op;
        acc_q     <= bus.acc_num;
        pin_q     <= bus.pin;
        new_pin_q <= bus.new_pin;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) pins_q[i] <= pin_reset(i);
    end else if (pin_we) begin
      pins_q[idx_q] <= new_pin_q;
    end
  end

  assign bus.req_ready     = (state_q == StIdle);
  assign bus.rsp_valid     = (state_q == StResp);
  assign bus.rsp_status    = status_q;
  assign bus.acc_index_out = index_q;
  assign bus.acc_found     = acc_found_q;

endmodule

// File: tb/tb_acc_auth_engine.sv
// Directed bench for acc_auth_engine: latency, status codes, PIN writes, handshake, reset.
// Lockout expectations follow AUTH_LOCKOUT_EN.
module tb_acc_auth_engine;

  localparam logic [1:0] OpVerify = 2'd0;
  localparam logic [1:0] OpChange = 2'd1;

  localparam int StatOk       = 0;
  localparam int StatNotFound = 1;
  localparam int StatBadPin   = 2;
  localparam int StatLocked   = 3;
  localparam int StatSamePin  = 4;
  localparam int StatBadOp    = 5;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  acc_auth_engine_if #(.ACC_W(4), .PIN_W(16)) bus ();

  acc_auth_engine #(
    .NUM_ACCOUNTS(10),
    .ACC_W       (4),
    .PIN_W       (16),
    .MAX_TRIES   (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Offers one request, counts edges from acceptance until rsp_valid, samples the response.
  task automatic run_req(input logic [1:0] op, input logic [3:0] acc, input logic [15:0] p,
                         input logic [15:0] np, output int lat, output int st,
                         output int ix, output int fd);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.acc_num   = acc;
    bus.pin       = p;
    bus.new_pin   = np;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    st = int'(bus.rsp_status);
    ix = int'(bus.acc_index_out);
    fd = int'(bus.acc_found);
    if (lat >= 40) check({"timeout_", "rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic req_check(input string tag, input logic [1:0] op, input logic [3:0] acc,
                           input logic [15:0] p, input logic [15:0] np, input int e_lat,
                           input int e_st, input int e_ix, input int e_fd);
    int lat, st, ix, fd;
    run_req(op, acc, p, np, lat, st, ix, fd);
    check({tag, "_lat"}, 32'(lat), 32'(e_lat));
    check({tag, "_status"}, 32'(st), 32'(e_st));
    check({tag, "_index"}, 32'(ix), 32'(e_ix));
    check({tag, "_found"}, 32'(fd), 32'(e_fd));
  endtask

  initial begin
    int lat;
    n_checks      = 0;
    n_errors      = 0;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.acc_num   = '0;
    bus.pin       = '0;
    bus.new_pin   = '0;
    bus.rsp_ready = 1'b1;
    pulse_reset();
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_status", 32'(bus.rsp_status), 32'd0);
    check("rst_index", 32'(bus.acc_index_out), 32'd0);
    check("rst_found", 32'(bus.acc_found), 32'd0);

    req_check("verify_acc3", OpVerify, 4'd3, 16'd3456, 16'd0, 4, StatOk, 2, 1);
    req_check("verify_acc11", OpVerify, 4'd11, 16'd1234, 16'd0, 11, StatNotFound, 0, 0);
    req_check("verify_acc0", OpVerify, 4'd0, 16'd1234, 16'd0, 11, StatNotFound, 0, 0);
    req_check("verify_acc10", OpVerify, 4'd10, 16'd7123, 16'd0, 11, StatOk, 9, 1);
    req_check("bad_op", 2'd3, 4'd3, 16'd3456, 16'd0, 0, StatBadOp, 0, 0);

    // Three wrong PINs, then the right one.
    for (int i = 0; i < 3; i++)
      req_check("lock_bad", OpVerify, 4'd1, 16'd1111, 16'd0, 2, StatBadPin, 0, 1);
`ifdef AUTH_LOCKOUT_EN
    req_check("lock_locked", OpVerify, 4'd1, 16'd1234, 16'd0, 2, StatLocked, 0, 1);
`else
    req_check("lock_nolock", OpVerify, 4'd1, 16'd1234, 16'd0, 2, StatOk, 0, 1);
`endif
    pulse_reset();
    req_check("lock_after_rst", OpVerify, 4'd1, 16'd1234, 16'd0, 2, StatOk, 0, 1);

    req_check("chg_same", OpChange, 4'd5, 16'd5678, 16'd5678, 6, StatSamePin, 4, 1);
    req_check("chg_ok", OpChange, 4'd5, 16'd5678, 16'd4321, 6, StatOk, 4, 1);
    req_check("chg_old_pin", OpVerify, 4'd5, 16'd5678, 16'd0, 6, StatBadPin, 4, 1);
    req_check("chg_new_pin", OpVerify, 4'd5, 16'd4321, 16'd0, 6, StatOk, 4, 1);
    req_check("chg_wrong_pin", OpChange, 4'd4, 16'd0, 16'd1, 5, StatBadPin, 3, 1);
    req_check("chg_no_write", OpVerify, 4'd4, 16'd4567, 16'd0, 5, StatOk, 3, 1);

    // Back-pressure with a stray request pulse during the search.
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = OpVerify;
    bus.acc_num   = 4'd3;
    bus.pin       = 16'd3456;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.acc_num   = 4'd1;
    bus.pin       = 16'd1234;
    check("hs_ready_search", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 2;
    while (!bus.rsp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("hs_lat", 32'(lat), 32'd4);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hs_hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("hs_hold_status", 32'(bus.rsp_status), 32'(StatOk));
      check("hs_hold_index", 32'(bus.acc_index_out), 32'd2);
      check("hs_hold_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hs_release_valid", 32'(bus.rsp_valid), 32'd0);
    check("hs_release_ready", 32'(bus.req_ready), 32'd1);

    // Reset just before a PIN change would commit.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = OpChange;
    bus.acc_num   = 4'd2;
    bus.pin       = 16'd2345;
    bus.new_pin   = 16'd9999;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_req_ready", 32'(bus.req_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
    req_check("abort_pin_kept", OpVerify, 4'd2, 16'd2345, 16'd0, 3, StatOk, 1, 1);
    req_check("abort_acc5_reset", OpVerify, 4'd5, 16'd5678, 16'd0, 6, StatOk, 4, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
